iir_sos_scheduler: RTL
======================

Name: iir_sos_scheduler

Overview:
- Time-multiplexed controller for the 6th-order Chebyshev bandstop IIR (three cascaded Direct Form II second-order sections).
- One shared multiply-accumulate datapath evaluates all sections in turn, one section at a time.
- Holds the per-section state registers (w1, w2) and a runtime-writable coefficient register file.
- Accepts one sample per valid/ready handshake and returns one filtered sample per valid/ready handshake; sits between the 360 Hz sample source and the downstream consumer.

Parameters:
- WL, 28, sample word length; signed, FL=13 fractional bits.
- CWL, 16, coefficient word length; signed.
- CFL, 14, coefficient fractional bits, giving a range of [-2, 2).
- NSEC, 3, number of cascaded sections.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x_in is valid.
- in_ready  out  1  block can accept a sample.
- x_in  in  WL  input sample, signed.
- out_valid  out  1  y_out is valid.
- out_ready  in  1  consumer accepts y_out.
- y_out  out  WL  filtered sample, signed.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  5  coefficient address = sec*5 + idx; idx order is A1, A2, B0, B1, B2.
- cfg_data  in  CWL  coefficient value.
- clr_state  in  1  zero all w1/w2 registers.
- busy  out  1  state is neither IDLE nor DONE.
- sat_evt  out  1  one-cycle pulse when any saturation occurs.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; in_ready=1; out_valid=0; y_out=0; busy=0; sat_evt=0.
  - All w1/w2 cleared.
  - Coefficients reset to passthrough: B0 = 1<<CFL (16384), all others 0.
  - Reset asserted mid-computation aborts the sample; no output is produced.
- States: IDLE, A1, A2, B0, B1, B2, WB, DONE.
- Handshakes:
  - in_ready = (state==IDLE).
  - Accept on in_valid & in_ready: latch x_in into sec_in, sec=0, go to A1.
- Per-section computation, one state per cycle:
  - A1: acc = (sec_in <<< CFL) - a1*w1.
  - A2: acc -= a2*w2.
  - B0: w = sat_WL(acc >>> CFL); acc = b0*w.
  - B1: acc += b1*w1.
  - B2: acc += b2*w2.
  - WB: y = sat_WL(acc >>> CFL); w2 <= w1; w1 <= w; sec_in <= y.
  - After WB: if sec == NSEC-1 go to DONE with y_out <= y; else sec++ and go to A1.
- Arithmetic:
  - acc is signed, WL+CWL+3 bits.
  - Right shift is arithmetic (truncation toward -inf).
  - sat_WL clamps to [-2^(WL-1), 2^(WL-1)-1] and pulses sat_evt the cycle after the clamp.
- Latency: out_valid rises exactly NSEC*6 = 18 clocks after the accepting edge.
- DONE:
  - out_valid=1 and y_out is held stable until out_ready.
  - On out_valid & out_ready, go to IDLE at that edge (in_ready=1 next cycle).
  - y_out keeps its last value after the handshake.
- Back-to-back throughput: one sample every 20 clocks with out_ready tied high.
- cfg_we:
  - Applied only when state==IDLE.
  - Ignored while busy or in DONE.
  - Ignored for cfg_addr >= NSEC*5.
- clr_state is honoured only in IDLE.
- If cfg_we and in_valid arrive in the same IDLE cycle, the coefficient write lands first and is used for that sample.
- Coefficient and state registers are not read combinationally by outputs.

Decomposition:
- Package iir_pkg:
  - State encoding.
  - Coefficient index constants: IDX_A1=0, IDX_A2=1, IDX_B0=2, IDX_B1=3, IDX_B2=4.
  - Default WL/FL/CWL/CFL.
  - Saturation function.
- Sub-module iir_sos_mac: single signed multiplier plus accumulator with ops LOAD_SHIFT, SUB, LOAD_MUL, ADD; op selected by the scheduler FSM.

Test Plan:
- Reset defaults: after reset, send x_in = 100<<13 (819200) -> y_out = 819200 with out_valid exactly 18 clocks after acceptance; a second sample of -819200 -> -819200.
- FIR path: write sec0 B0=8192 and B1=8192 (0.5 each); send 819200, then 0, 0 -> outputs 409600, 409600, 0.
- Feedback: write sec0 A1=-8192 (-0.5); send impulse 8192, then zeros -> outputs 8192, 4096, 2048, 1024.
- Backpressure and config lockout:
  - Hold out_ready=0 for 10 cycles in DONE -> y_out stable, in_ready=0, a pending in_valid is not taken.
  - A cfg_we during busy leaves the coefficient unchanged (verified by the next passthrough sample).
- Saturation: set B0=32767 in all sections and send x_in = 2^27-1 -> y_out = 134217727 and at least one sat_evt pulse; send -2^27 -> y_out = -134217728.
- Reset mid-op: drive reset_n low during sec=1 state B1 -> immediately out_valid=0, in_ready=1; coefficients back to passthrough; the next sample of 819200 returns 819200.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants, state/op encodings and saturation helpers for the
// time-multiplexed second-order-section IIR scheduler.
package iir_pkg;

    localparam int WL    = 28;
    localparam int FL    = 13;
    localparam int CWL   = 16;
    localparam int CFL   = 14;
    localparam int NSEC  = 3;
    localparam int NCOEF = NSEC * 5;
    localparam int CAW   = $clog2(NCOEF);
    localparam int SECW  = $clog2(NSEC);
    localparam int ACCW  = WL + CWL + 3;

    localparam logic [2:0] IDX_A1 = 3'd0;
    localparam logic [2:0] IDX_A2 = 3'd1;
    localparam logic [2:0] IDX_B0 = 3'd2;
    localparam logic [2:0] IDX_B1 = 3'd3;
    localparam logic [2:0] IDX_B2 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A1,
        ST_A2,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_WB,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        MAC_HOLD,
        MAC_LOAD_SHIFT,
        MAC_SUB,
        MAC_LOAD_MUL,
        MAC_ADD
    } mac_op_e;

    // True when v does not fit in a signed WL-bit word.
    function automatic logic sat_hit(input logic signed [ACCW-1:0] v);
        return !((&v[ACCW-1:WL-1]) || !(|v[ACCW-1:WL-1]));
    endfunction

    // Clamp v to the signed WL-bit range.
    function automatic logic signed [WL-1:0] sat_wl(input logic signed [ACCW-1:0] v);
        if (!sat_hit(v))
            return v[WL-1:0];
        else if (v[ACCW-1])
            return {1'b1, {(WL-1){1'b0}}};
        else
            return {1'b0, {(WL-1){1'b1}}};
    endfunction

endpackage

// File: rtl/iir_sos_mac.sv
// Single signed multiplier feeding one wide accumulator; the scheduler
// picks the accumulate operation each cycle.
module iir_sos_mac
    import iir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  mac_op_e                op_i,
    input  logic signed [CWL-1:0]  coef_i,
    input  logic signed [WL-1:0]   data_i,
    input  logic signed [WL-1:0]   x_i,
    output logic signed [ACCW-1:0] acc_o
);

    localparam int PW = CWL + WL;

    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] x_ext;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;

    assign prod     = PW'(coef_i) * PW'(data_i);
    assign prod_ext = ACCW'(prod);
    assign x_ext    = ACCW'(x_i) <<< CFL;
    assign acc_o    = acc_q;

    // Accumulator next value for the selected operation.
    always_comb begin
        acc_d = acc_q;
        case (op_i)
            MAC_LOAD_SHIFT: acc_d = x_ext - prod_ext;
            MAC_SUB:        acc_d = acc_q - prod_ext;
            MAC_LOAD_MUL:   acc_d = prod_ext;
            MAC_ADD:        acc_d = acc_q + prod_ext;
            default:        acc_d = acc_q;
        endcase
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/iir_sos_scheduler.sv
// Sequences the shared MAC through A1, A2, B0, B1, B2, WB for each cascaded
// section, owning the w1/w2 delay lines and the coefficient register file.
//
// state | meaning
// IDLE  | waiting for a sample; config writes and clr_state accepted here
// A1    | acc = (sec_in << CFL) - a1*w1
// A2    | acc -= a2*w2
// B0    | w = sat(acc >> CFL); acc = b0*w
// B1    | acc += b1*w1
// B2    | acc += b2*w2
// WB    | y = sat(acc >> CFL); shift delay line; next section or finish
// DONE  | y_out valid, waiting for out_ready
module iir_sos_scheduler
    import iir_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [WL-1:0]  x_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [WL-1:0]  y_out,
    input  logic                  cfg_we,
    input  logic [4:0]            cfg_addr,
    input  logic signed [CWL-1:0] cfg_data,
    input  logic                  clr_state,
    output logic                  busy,
    output logic                  sat_evt
);

    state_e                 state_q, state_d;
    logic [SECW-1:0]        sec_q;
    logic signed [WL-1:0]   sec_in_q;
    logic signed [WL-1:0]   w_q;
    logic signed [WL-1:0]   y_q;
    logic                   sat_q;
    logic signed [WL-1:0]   w1_q [NSEC];
    logic signed [WL-1:0]   w2_q [NSEC];
    logic signed [CWL-1:0]  coef_q [NCOEF];

    mac_op_e                mac_op;
    logic [2:0]             idx;
    logic [CAW-1:0]         csel;
    logic signed [WL-1:0]   mac_data;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_shr;
    logic signed [WL-1:0]   acc_sat;
    logic                   acc_hit;
    logic                   last_sec;
    logic                   cfg_ok;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign y_out     = y_q;
    assign sat_evt   = sat_q;

    assign acc_shr  = acc >>> CFL;
    assign acc_sat  = sat_wl(acc_shr);
    assign acc_hit  = sat_hit(acc_shr);
    assign last_sec = (sec_q == SECW'(NSEC - 1));
    assign csel     = CAW'(sec_q) * CAW'(5) + CAW'(idx);
    assign cfg_ok   = (state_q == ST_IDLE) && cfg_we && (cfg_addr < 5'(NCOEF));

    iir_sos_mac u_mac (
        .clk    (clk),
        .rst_n  (reset_n),
        .op_i   (mac_op),
        .coef_i (coef_q[csel]),
        .data_i (mac_data),
        .x_i    (sec_in_q),
        .acc_o  (acc)
    );

    // Operand and operation selection for the shared MAC.
    always_comb begin
        mac_op   = MAC_HOLD;
        idx      = IDX_B0;
        mac_data = '0;
        case (state_q)
            ST_A1: begin mac_op = MAC_LOAD_SHIFT; idx = IDX_A1; mac_data = w1_q[sec_q]; end
            ST_A2: begin mac_op = MAC_SUB;        idx = IDX_A2; mac_data = w2_q[sec_q]; end
            ST_B0: begin mac_op = MAC_LOAD_MUL;   idx = IDX_B0; mac_data = acc_sat;     end
            ST_B1: begin mac_op = MAC_ADD;        idx = IDX_B1; mac_data = w1_q[sec_q]; end
            ST_B2: begin mac_op = MAC_ADD;        idx = IDX_B2; mac_data = w2_q[sec_q]; end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_A1;
            ST_A1:   state_d = ST_A2;
            ST_A2:   state_d = ST_B0;
            ST_B0:   state_d = ST_B1;
            ST_B1:   state_d = ST_B2;
            ST_B2:   state_d = ST_WB;
            ST_WB:   state_d = last_sec ? ST_DONE : ST_A1;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Section counter, section input, intermediate w, output and saturation flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_q    <= '0;
            sec_in_q <= '0;
            w_q      <= '0;
            y_q      <= '0;
            sat_q    <= 1'b0;
        end else begin
            sat_q <= ((state_q == ST_B0) || (state_q == ST_WB)) && acc_hit;
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    sec_in_q <= x_in;
                    sec_q    <= '0;
                end
                ST_B0: w_q <= acc_sat;
                ST_WB: begin
                    sec_in_q <= acc_sat;
                    if (last_sec) y_q   <= acc_sat;
                    else          sec_q <= sec_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Per-section delay lines: shifted on write-back, cleared on request while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSEC; i++) begin
                w1_q[i] <= '0;
                w2_q[i] <= '0;
            end
        end else if (state_q == ST_WB) begin
            w2_q[sec_q] <= w1_q[sec_q];
            w1_q[sec_q] <= w_q;
        end else if ((state_q == ST_IDLE) && clr_state) begin
            for (int i = 0; i < NSEC; i++) begin
                w1_q[i] <= '0;
                w2_q[i] <= '0;
            end
        end
    end

    // Coefficient file: passthrough after reset, writable only while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCOEF; i++)
                coef_q[i] <= ((i % 5) == int'(IDX_B0)) ? CWL'(1 << CFL) : '0;
        end else if (cfg_ok) begin
            coef_q[cfg_addr[CAW-1:0]] <= cfg_data;
        end
    end

endmodule
